proc_sequencer: RTL



---
 rtl/proc_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/proc_sequencer.sv
// Instruction sequencer: fetches 9-bit words from a synchronous ROM and issues them to a processor.
// Latency: Go or retire to Run is 2 cycles (FETCH, ISSUE); a load operand is on DIN the cycle after Run.
// Backpressure: holds in WAIT until Done, for at most TMO_CYC cycles, then stops with sticky Err.
// Optional single-step gating after each retire is enabled by defining PROC_SEQ_STEP_EN.
module proc_sequencer #(
   parameter int ADDR_W  = 5,
   parameter int TMO_CYC = 7
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Go,
   input  logic              Halt,
`ifdef PROC_SEQ_STEP_EN
   input  logic              Step,
`endif
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [8:0]        mem_q,
   output logic [8:0]        DIN,
   output logic              Run,
   input  logic              Done,
   output logic              Busy,
   output logic              Err,
   output logic [ADDR_W-1:0] PC,
   output logic [7:0]        retired
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT,
      S_HALTED,
      S_ERROR
`ifdef PROC_SEQ_STEP_EN
      , S_STEPWAIT
`endif
   } state_t;

   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_HALT = 3'b111;

   // The timeout counter runs 0..TMO_CYC-1 across the WAIT cycles
   localparam int TW = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC);
   localparam logic [TW-1:0]     TMO_LAST = TW'(TMO_CYC - 1);
   localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] PC_TWO   = ADDR_W'(2);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [7:0]        ret_q, ret_d;
   logic              err_q, err_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic              load_q, load_d;

   assign DIN     = mem_q;
   assign PC      = pc_q;
   assign retired = ret_q;
   assign Err     = err_q;

   // State and datapath registers; reset abandons any in-flight instruction
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         ret_q   <= '0;
         err_q   <= 1'b0;
         tmo_q   <= '0;
         load_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ret_q   <= ret_d;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
         load_q  <= load_d;
      end
   end

   // Next-state, datapath updates and ROM address / strobe generation
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ret_d    = ret_q;
      err_d    = err_q;
      tmo_d    = tmo_q;
      load_d   = load_q;
      mem_addr = pc_q;
      Run      = 1'b0;
      Busy     = 1'b0;
      case (state_q)
         S_IDLE, S_HALTED, S_ERROR: begin
            if (Go) begin
               pc_d    = '0;
               ret_d   = '0;
               state_d = S_FETCH;
               if (state_q == S_ERROR) err_d = 1'b0;
            end
         end
         S_FETCH: begin
            Busy    = 1'b1;
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            Busy = 1'b1;
            if (mem_q[8:6] == OP_HALT) begin
               state_d = S_HALTED;
            end else begin
               // Pre-address the next word so a load operand lands on DIN in WAIT
               Run      = 1'b1;
               mem_addr = pc_q + PC_ONE;
               load_d   = (mem_q[8:6] == OP_LOAD);
               tmo_d    = '0;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            Busy     = 1'b1;
            mem_addr = pc_q + PC_ONE;
            if (Done) begin
               pc_d  = pc_q + (load_q ? PC_TWO : PC_ONE);
               ret_d = ret_q + 8'd1;
               if (Halt) state_d = S_IDLE;
`ifdef PROC_SEQ_STEP_EN
               else      state_d = S_STEPWAIT;
`else
               else      state_d = S_FETCH;
`endif
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = S_ERROR;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
`ifdef PROC_SEQ_STEP_EN
         S_STEPWAIT: begin
            Busy = 1'b1;
            if (Step) state_d = S_FETCH;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

endmodule
